// File: rtl/sum_ascii_framer.sv
// sum_ascii_framer: turns the 5-bit adder result into an ASCII decimal text
// frame such as "S=27\r\n" and feeds it to uart_tx one byte at a time over
// the uart_tx enable/busy handshake.
//
// Handshake with uart_tx:
//   uart_tx_en is a registered single-cycle strobe, issued only in a cycle in
//   which uart_tx_busy was seen low. uart_tx_data is valid in the strobe cycle
//   and is held unchanged until uart_tx_busy has been seen high and then low
//   again. uart_tx_busy may rise one or more cycles after the strobe.
//
// Triggering:
//   trig = send_req | (AUTO_SEND & sum_in != prev_sum), where prev_sum follows
//   sum_in every cycle. A trigger while a frame is running is remembered in a
//   one-deep queue (newest value wins) and starts the next frame straight from
//   DONE.
module sum_ascii_framer #(
    parameter bit SEND_PREFIX = 1'b1,
    parameter bit AUTO_SEND   = 1'b1,
    parameter bit EOL_CRLF    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] sum_in,
    input  logic       send_req,
    input  logic       uart_tx_busy,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       pending,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Byte positions inside the frame; the prefix shifts everything by two.
    localparam logic [2:0] TENS_IDX  = SEND_PREFIX ? 3'd2 : 3'd0;
    localparam logic [2:0] UNITS_IDX = TENS_IDX + 3'd1;
    localparam logic [2:0] CR_IDX    = UNITS_IDX + 3'd1;
    localparam logic [2:0] LAST_IDX  = EOL_CRLF ? (UNITS_IDX + 3'd2) : (UNITS_IDX + 3'd1);

    state_t     state;
    logic [4:0] prev_sum;
    logic [4:0] snapshot;
    logic [4:0] queued_sum;
    logic [2:0] idx;

    logic       trig;
    logic [1:0] tens;
    logic [4:0] units;
    logic [7:0] cur_byte;

    assign trig      = send_req | (AUTO_SEND & (sum_in != prev_sum));
    assign state_dbg = state;

    // Split the latched sum into two decimal digits without a divider.
    always_comb begin
        tens  = 2'd0;
        units = snapshot;
        if (snapshot >= 5'd30) begin
            tens  = 2'd3;
            units = snapshot - 5'd30;
        end else if (snapshot >= 5'd20) begin
            tens  = 2'd2;
            units = snapshot - 5'd20;
        end else if (snapshot >= 5'd10) begin
            tens  = 2'd1;
            units = snapshot - 5'd10;
        end
    end

    // Select the frame byte addressed by the byte index.
    always_comb begin
        cur_byte = 8'h0A;
        if (SEND_PREFIX && idx == 3'd0) begin
            cur_byte = 8'h53;
        end else if (SEND_PREFIX && idx == 3'd1) begin
            cur_byte = 8'h3D;
        end else if (idx == TENS_IDX) begin
            cur_byte = 8'h30 + {6'd0, tens};
        end else if (idx == UNITS_IDX) begin
            cur_byte = 8'h30 + {3'd0, units};
        end else if (EOL_CRLF && idx == CR_IDX) begin
            cur_byte = 8'h0D;
        end
    end

    // Frame sequencer: trigger capture, byte handshake and one-deep request queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            pending      <= 1'b0;
            prev_sum     <= 5'd0;
            snapshot     <= 5'd0;
            queued_sum   <= 5'd0;
            idx          <= 3'd0;
        end else begin
            prev_sum   <= sum_in;
            uart_tx_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        snapshot   <= sum_in;
                        idx        <= 3'd0;
                        frame_busy <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (trig) begin
                        pending    <= 1'b1;
                        queued_sum <= sum_in;
                    end
                    uart_tx_data <= cur_byte;
                    if (!uart_tx_busy) begin
                        uart_tx_en <= 1'b1;
                        state      <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (trig) begin
                        pending    <= 1'b1;
                        queued_sum <= sum_in;
                    end
                    if (uart_tx_busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (trig) begin
                        pending    <= 1'b1;
                        queued_sum <= sum_in;
                    end
                    if (!uart_tx_busy) begin
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            frame_busy <= 1'b0;
                            state      <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    // A trigger arriving right now is newer than anything queued.
                    if (trig || pending) begin
                        snapshot   <= trig ? sum_in : queued_sum;
                        pending    <= 1'b0;
                        idx        <= 3'd0;
                        frame_busy <= 1'b1;
                        state      <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
